multicycle_lookahead_adder: RTL

- Multi-cycle adder built from carry-lookahead groups.
- Processes one GROUP-bit slice per clock, least-significant slice first, and registers the ripple carry between slices.
- Produces the sum, the carry out, and the word-level group propagate/generate.
- Sits beside the ALU as a low-area adder option; uses a valid/ready handshake on both input and output.

---
 rtl/multicycle_adder_pkg.sv | 15 +
 rtl/multicycle_lookahead_adder_group.sv | 33 +++
 rtl/multicycle_lookahead_adder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/multicycle_adder_pkg.sv
// Shared types and helpers for the multi-cycle lookahead adder.
// FSM state encoding plus the slice-count helper used at elaboration.
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int steps(input int width, input int group);
    return (group > 0) ? (width / group) : 0;
  endfunction

endpackage

// File: rtl/multicycle_lookahead_adder_group.sv
// One carry-lookahead group: every internal carry is formed from prefix
// generate/propagate terms and the group carry-in, not rippled bit to bit.
module lookahead_group #(
  parameter int GROUP = 2
) (
  input  logic [GROUP-1:0] i_p,
  input  logic [GROUP-1:0] i_g,
  input  logic             i_c,
  output logic [GROUP-1:0] o_c,
  output logic             o_cout,
  output logic             o_pg,
  output logic             o_gg
);

  // NOTE: blocking assignments are correct here; v_g/v_p are combinational
  // temporaries that each loop iteration must see updated immediately.
  always_comb begin : prefix
    logic v_g;
    logic v_p;
    v_g    = 1'b0;
    v_p    = 1'b1;
    o_c    = '0;
    for (int i = 0; i < GROUP; i++) begin
      o_c[i] = v_g | (v_p & i_c);
      v_g    = i_g[i] | (i_p[i] & v_g);
      v_p    = v_p & i_p[i];
    end
    o_gg   = v_g;
    o_pg   = v_p;
    o_cout = v_g | (v_p & i_c);
  end

endmodule

// File: rtl/multicycle_lookahead_adder.sv
// Low-area adder: resolves one GROUP-bit slice per clock, LSB slice first.
// Optional subtract mode via `define MULTICYCLE_LOOKAHEAD_ADDER_SUB_EN.
module multicycle_lookahead_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GROUP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
`ifdef MULTICYCLE_LOOKAHEAD_ADDER_SUB_EN
  input  logic             sub_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             pg_out,
  output logic             gg_out
);

  localparam int STEPS = steps(WIDTH, GROUP);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_cfg
    $error("multicycle_lookahead_adder: WIDTH must be a positive multiple of GROUP");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_pg;
  logic             r_gg;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;
  logic [GROUP-1:0] w_a_slice;
  logic [GROUP-1:0] w_b_slice;
  logic [GROUP-1:0] w_p;
  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_c;
  logic [GROUP-1:0] w_sum_slice;
  logic             w_cout;
  logic             w_pg;
  logic             w_gg;

`ifdef MULTICYCLE_LOOKAHEAD_ADDER_SUB_EN
  // Subtract is A + ~B + 1, so c_in is ignored in that mode.
  assign w_b_eff = sub_in ? ~b_in : b_in;
  assign w_c_eff = sub_in ? 1'b1  : c_in;
`else
  assign w_b_eff = b_in;
  assign w_c_eff = c_in;
`endif

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int k = 0; k < STEPS; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_a_slice = r_a[k*GROUP +: GROUP];
        w_b_slice = r_b[k*GROUP +: GROUP];
      end
    end
  end

  assign w_p         = w_a_slice ^ w_b_slice;
  assign w_g         = w_a_slice & w_b_slice;
  assign w_sum_slice = w_p ^ w_c;

  lookahead_group #(
    .GROUP (GROUP)
  ) u_group (
    .i_p    (w_p),
    .i_g    (w_g),
    .i_c    (r_carry),
    .o_c    (w_c),
    .o_cout (w_cout),
    .o_pg   (w_pg),
    .o_gg   (w_gg)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_pg    <= 1'b0;
      r_gg    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a_in;
            r_b     <= w_b_eff;
            r_carry <= w_c_eff;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_gg    <= 1'b0;
            r_pg    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < STEPS; k++) begin
            if (r_cnt == CNT_W'(k)) r_sum[k*GROUP +: GROUP] <= w_sum_slice;
          end
          r_carry <= w_cout;
          r_pg    <= r_pg & w_pg;
          r_gg    <= w_gg | (w_pg & r_gg);
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum_out   = r_sum;
  assign c_out     = r_carry;
  assign pg_out    = r_pg;
  assign gg_out    = r_gg;

endmodule
